// File: rtl/acc_seq_8bit.sv
// -----------------------------------------------------------------------------
// acc_seq_8bit
//
// Sequencer and accumulator stage wrapped around an external 8-bit
// add/subtract datapath. It takes commands (LOAD, ADD, SUB, MUL), drives the
// adder operands and registers the adder result into an 8-bit accumulator.
// It also maintains C/V/Z/N flags. MUL is built from repeated additions
// through the same adder.
//
// Handshake: a command transfers on the rising edge where
// cmd_valid && cmd_ready. cmd_ready depends only on the FSM state (high only
// in IDLE), so it never depends on cmd_valid. A source that sees
// cmd_ready=0 must keep cmd_valid, cmd_op and cmd_data stable until the
// transfer edge.
//
// Ports
//   clk        in   1  clock, all state updates on the rising edge
//   rst        in   1  synchronous, active-high reset
//   cmd_valid  in   1  command present
//   cmd_ready  out  1  command can be accepted (IDLE only)
//   cmd_op     in   2  00 LOAD, 01 ADD, 10 SUB, 11 MUL
//   cmd_data   in   8  operand
//   add_a      out  8  adder operand A
//   add_b      out  8  adder operand B (the adder inverts it when add_ci=1)
//   add_ci     out  1  adder carry-in / subtract select
//   add_s      in   8  adder sum
//   add_c6     in   1  adder carry into bit 7
//   add_c7     in   1  adder carry out of bit 7
//   acc        out  8  accumulator
//   flag_c     out  1  carry (for SUB, 1 = no borrow)
//   flag_v     out  1  signed overflow
//   flag_z     out  1  accumulator is zero
//   flag_n     out  1  accumulator bit 7
//   done       out  1  one-cycle pulse after acc/flags are written
//   dbg_state  out  2  current FSM state (0 IDLE, 1 EXEC, 2 MUL)
// -----------------------------------------------------------------------------
module acc_seq_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    output logic [7:0] add_a,
    output logic [7:0] add_b,
    output logic       add_ci,
    input  logic [7:0] add_s,
    input  logic       add_c6,
    input  logic       add_c7,
    output logic [7:0] acc,
    output logic       flag_c,
    output logic       flag_v,
    output logic       flag_z,
    output logic       flag_n,
    output logic       done,
    output logic [1:0] dbg_state
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [1:0] op_r;
    logic [7:0] data_r;
    logic [7:0] mcand;
    logic [7:0] count;
    logic       sticky_c;

    logic       accept;
    logic [7:0] exec_val;
    logic       exec_c;
    logic       exec_v;
    logic       mul_c;

    assign dbg_state = state;
    assign accept    = cmd_valid && cmd_ready;
    // Carry seen on any partial add, including the one happening right now.
    // On the final add this becomes both C and V.
    assign mul_c     = sticky_c | add_c7;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the outputs that depend only on the state
    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        add_a      = acc;
        add_b      = 8'h00;
        add_ci     = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    // A MUL by zero has no adds to do. It goes through EXEC
                    // so that its latency matches the single-cycle ops.
                    if (cmd_op == OP_MUL && cmd_data != 8'h00) begin
                        state_next = S_MUL;
                    end else begin
                        state_next = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                add_b      = data_r;
                add_ci     = (op_r == OP_SUB);
                state_next = S_IDLE;
            end
            S_MUL: begin
                add_b = mcand;
                if (count == 8'd1) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Result of the single EXEC cycle, chosen by the latched opcode
    always_comb begin
        exec_val = 8'h00;
        exec_c   = 1'b0;
        exec_v   = 1'b0;
        case (op_r)
            OP_LOAD: exec_val = data_r;
            OP_ADD, OP_SUB: begin
                exec_val = add_s;
                exec_c   = add_c7;
                exec_v   = add_c6 ^ add_c7;
            end
            default: exec_val = 8'h00;  // MUL by zero
        endcase
    end

    // Datapath: latched command, accumulator, flags, MUL bookkeeping, done
    always_ff @(posedge clk) begin
        if (rst) begin
            op_r     <= OP_LOAD;
            data_r   <= 8'h00;
            mcand    <= 8'h00;
            count    <= 8'h00;
            sticky_c <= 1'b0;
            acc      <= 8'h00;
            flag_c   <= 1'b0;
            flag_v   <= 1'b0;
            flag_z   <= 1'b0;
            flag_n   <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r   <= cmd_op;
                        data_r <= cmd_data;
                        if (cmd_op == OP_MUL && cmd_data != 8'h00) begin
                            // The current acc becomes the multiplicand. The
                            // product is built up from zero.
                            mcand    <= acc;
                            acc      <= 8'h00;
                            count    <= cmd_data;
                            sticky_c <= 1'b0;
                        end
                    end
                end
                S_EXEC: begin
                    acc    <= exec_val;
                    flag_c <= exec_c;
                    flag_v <= exec_v;
                    flag_z <= (exec_val == 8'h00);
                    flag_n <= exec_val[7];
                    done   <= 1'b1;
                end
                S_MUL: begin
                    acc      <= add_s;
                    count    <= count - 8'd1;
                    sticky_c <= mul_c;
                    if (count == 8'd1) begin
                        flag_c <= mul_c;
                        flag_v <= mul_c;
                        flag_z <= (add_s == 8'h00);
                        flag_n <= add_s[7];
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_seq_8bit.sv
// -----------------------------------------------------------------------------
// tb_acc_seq_8bit
//
// Directed bench for acc_seq_8bit. An ideal 8-bit add/subtract datapath
// closes the loop. Each scenario task drives its own commands and compares
// the outputs with hand-computed values. Inputs change on the falling edge
// and outputs are sampled on the falling edge. Latency is counted in falling
// edges after the accept edge.
// -----------------------------------------------------------------------------
module tb_acc_seq_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_ci;
    logic [7:0] add_s;
    logic       add_c6;
    logic       add_c7;
    logic [7:0] acc;
    logic       flag_c;
    logic       flag_v;
    logic       flag_z;
    logic       flag_n;
    logic       done;
    logic [1:0] dbg_state;

    int pass_cnt = 0;
    int total_cnt = 0;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_MUL  = 2'b11;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- ideal adder ----------------
    logic [7:0] b_eff;
    logic [8:0] full_sum;
    logic [7:0] low_sum;
    assign b_eff    = add_ci ? ~add_b : add_b;
    assign full_sum = {1'b0, add_a} + {1'b0, b_eff} + {8'h00, add_ci};
    assign low_sum  = {1'b0, add_a[6:0]} + {1'b0, b_eff[6:0]} + {7'h00, add_ci};
    assign add_s    = full_sum[7:0];
    assign add_c7   = full_sum[8];
    assign add_c6   = low_sum[7];

    acc_seq_8bit dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_ci    (add_ci),
        .add_s     (add_s),
        .add_c6    (add_c6),
        .add_c7    (add_c7),
        .acc       (acc),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // ---------------- driver ----------------
    // Presents one command and returns at the falling edge where done is
    // first seen. lat is the number of falling edges from the accept edge to
    // that edge. It is -1 if ready or done never came.
    task automatic send_cmd(input logic [1:0] op, input logic [7:0] data, output int lat);
        int w;
        lat = -1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 300) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b1;          // offered during reset, must be ignored
        cmd_op    = OP_LOAD;
        cmd_data  = 8'hAA;
        repeat (3) @(negedge clk);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (acc !== 8'h00) $display("FAIL reset_acc: got %h want 00", acc);
        else pass_cnt++;
        total_cnt++;
        if ({flag_c, flag_v, flag_z, flag_n} !== 4'b0000)
            $display("FAIL reset_flags: got %b want 0000", {flag_c, flag_v, flag_z, flag_n});
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || dbg_state !== 2'd0)
            $display("FAIL reset_ctrl: done=%b ready=%b state=%0d want 0 1 0", done, cmd_ready, dbg_state);
        else pass_cnt++;
        total_cnt++;
        if (add_b !== 8'h00 || add_ci !== 1'b0)
            $display("FAIL idle_adder_ops: add_b=%h add_ci=%b want 00 0", add_b, add_ci);
        else pass_cnt++;
    endtask

    task automatic test_add();
        int lat;
        send_cmd(OP_LOAD, 8'h7F, lat);
        total_cnt++;
        if (lat !== 2 || acc !== 8'h7F) $display("FAIL load_7f: lat=%0d acc=%h want 2 7f", lat, acc);
        else pass_cnt++;
        send_cmd(OP_ADD, 8'h01, lat);
        total_cnt++;
        if (lat !== 2) $display("FAIL add_latency: got %0d want 2", lat);
        else pass_cnt++;
        total_cnt++;
        if (acc !== 8'h80 || {flag_c, flag_v, flag_n, flag_z} !== 4'b0110)
            $display("FAIL add_result: acc=%h cvnz=%b want 80 0110", acc, {flag_c, flag_v, flag_n, flag_z});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0 || acc !== 8'h80) $display("FAIL done_pulse_width: done=%b acc=%h want 0 80", done, acc);
        else pass_cnt++;
    endtask

    task automatic test_sub();
        int lat;
        send_cmd(OP_LOAD, 8'h05, lat);
        send_cmd(OP_SUB, 8'h05, lat);
        total_cnt++;
        if (lat !== 2 || acc !== 8'h00 || {flag_c, flag_v, flag_n, flag_z} !== 4'b1001)
            $display("FAIL sub_to_zero: lat=%0d acc=%h cvnz=%b want 2 00 1001", lat, acc, {flag_c, flag_v, flag_n, flag_z});
        else pass_cnt++;
        send_cmd(OP_SUB, 8'h01, lat);
        total_cnt++;
        if (acc !== 8'hFF || {flag_c, flag_v, flag_n, flag_z} !== 4'b0010)
            $display("FAIL sub_borrow: acc=%h cvnz=%b want ff 0010", acc, {flag_c, flag_v, flag_n, flag_z});
        else pass_cnt++;
    endtask

    task automatic test_mul();
        int lat;
        send_cmd(OP_LOAD, 8'h03, lat);
        send_cmd(OP_MUL, 8'h05, lat);
        total_cnt++;
        if (lat !== 6) $display("FAIL mul5_latency: got %0d want 6", lat);
        else pass_cnt++;
        total_cnt++;
        if (acc !== 8'h0F || {flag_c, flag_v, flag_n, flag_z} !== 4'b0000)
            $display("FAIL mul5_result: acc=%h cvnz=%b want 0f 0000", acc, {flag_c, flag_v, flag_n, flag_z});
        else pass_cnt++;
    endtask

    task automatic test_mul_overflow();
        int lat;
        send_cmd(OP_LOAD, 8'h20, lat);
        send_cmd(OP_MUL, 8'h10, lat);
        total_cnt++;
        if (lat !== 17) $display("FAIL mul16_latency: got %0d want 17", lat);
        else pass_cnt++;
        total_cnt++;
        if (acc !== 8'h00 || {flag_c, flag_v, flag_n, flag_z} !== 4'b1101)
            $display("FAIL mul16_result: acc=%h cvnz=%b want 00 1101", acc, {flag_c, flag_v, flag_n, flag_z});
        else pass_cnt++;
        send_cmd(OP_LOAD, 8'h37, lat);
        send_cmd(OP_MUL, 8'h00, lat);
        total_cnt++;
        if (lat !== 2 || acc !== 8'h00 || {flag_c, flag_v, flag_n, flag_z} !== 4'b0001)
            $display("FAIL mul_zero: lat=%0d acc=%h cvnz=%b want 2 00 0001", lat, acc, {flag_c, flag_v, flag_n, flag_z});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        int done_seen;
        send_cmd(OP_LOAD, 8'h02, lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_MUL;
        cmd_data  = 8'h09;
        @(posedge clk);            // accept edge
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        // Two adds done so far: 0 -> 2 -> 4
        total_cnt++;
        if (acc !== 8'h04 || cmd_ready !== 1'b0)
            $display("FAIL mul_partial: acc=%h ready=%b want 04 0", acc, cmd_ready);
        else pass_cnt++;
        rst = 1'b1;                // sampled at accept+3
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        total_cnt++;
        if (acc !== 8'h00 || {flag_c, flag_v, flag_z, flag_n} !== 4'b0000 || cmd_ready !== 1'b1)
            $display("FAIL mid_mul_reset: acc=%h flags=%b ready=%b want 00 0000 1", acc,
                     {flag_c, flag_v, flag_z, flag_n}, cmd_ready);
        else pass_cnt++;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) done_seen++;
            @(negedge clk);
        end
        total_cnt++;
        if (done_seen !== 0 || acc !== 8'h00)
            $display("FAIL abort_no_done: done pulses=%0d acc=%h want 0 00", done_seen, acc);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int busy;
        send_cmd(OP_LOAD, 8'h03, lat);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_MUL;
        cmd_data  = 8'h05;
        @(posedge clk);            // MUL accepted
        @(negedge clk);
        cmd_op   = OP_LOAD;        // new op held while busy
        cmd_data = 8'h44;
        lat  = 1;
        busy = 0;
        while (done !== 1'b1 && lat < 50) begin
            if (cmd_ready === 1'b0) busy++;
            @(negedge clk);
            lat++;
        end
        total_cnt++;
        if (lat !== 6 || busy !== 5 || acc !== 8'h0F || cmd_ready !== 1'b1)
            $display("FAIL b2b_mul: lat=%0d busy=%0d acc=%h ready=%b want 6 5 0f 1", lat, busy, acc, cmd_ready);
        else pass_cnt++;
        @(posedge clk);            // held LOAD accepted, same cycle as done
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++;
        if (acc !== 8'h0F || done !== 1'b0 || cmd_ready !== 1'b0)
            $display("FAIL b2b_exec: acc=%h done=%b ready=%b want 0f 0 0", acc, done, cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (acc !== 8'h44 || done !== 1'b1 || {flag_c, flag_v} !== 2'b00)
            $display("FAIL b2b_load: acc=%h done=%b cv=%b want 44 1 00", acc, done, {flag_c, flag_v});
        else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_LOAD;
        cmd_data  = 8'h00;
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_mul_overflow();
        test_reset_mid_mul();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
